// File: rtl/iir_chan_sched_if.sv
// Sample, result, coefficient-config and control bundle of the shared-multiplier biquad scheduler.
// Sample path is valid/ready; results are a one-cycle out_valid pulse with no backpressure.
interface iir_chan_sched_if #(
   parameter int CH_W = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [CH_W-1:0]        in_ch;
   logic signed [31:0]     in_x;

   logic                   out_valid;
   logic [CH_W-1:0]        out_ch;
   logic signed [31:0]     out_y;

   logic                   cfg_we;
   logic [CH_W-1:0]        cfg_ch;
   logic [2:0]             cfg_sel;
   logic signed [31:0]     cfg_data;

   logic                   st_clr;
   logic                   busy;

   modport master (
      output in_valid, in_ch, in_x, cfg_we, cfg_ch, cfg_sel, cfg_data, st_clr,
      input  in_ready, out_valid, out_ch, out_y, busy
   );

   modport slave (
      input  in_valid, in_ch, in_x, cfg_we, cfg_ch, cfg_sel, cfg_data, st_clr,
      output in_ready, out_valid, out_ch, out_y, busy
   );
endinterface

// File: rtl/iir_chan_sched.sv
// NCH-channel Q27 transposed-DF2 biquad sharing one 32x32 multiplier; out_valid 6 cycles after accept.
// One sample in flight: in_ready drops for 6 cycles after acceptance, giving one sample per 7 cycles.
module iir_chan_sched #(
   parameter int NCH   = 4,
   parameter int CH_W  = 2,
   parameter int QBITS = 27
) (
   input logic              clk,
   input logic              reset,
   iir_chan_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P_B1 = 3'd1,
      P_B2 = 3'd2,
      P_A2 = 3'd3,
      P_B3 = 3'd4,
      P_A3 = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;

   // per-channel coefficient bank and history
   logic signed [31:0] b1_bank [NCH];
   logic signed [31:0] b2_bank [NCH];
   logic signed [31:0] b3_bank [NCH];
   logic signed [31:0] a2_bank [NCH];
   logic signed [31:0] a3_bank [NCH];
   logic signed [63:0] n1_bank [NCH];
   logic signed [63:0] n2_bank [NCH];

   // working registers for the sample in flight
   logic signed [31:0] x_r;
   logic signed [31:0] y_r;
   logic signed [31:0] c_b1, c_b2, c_b3, c_a2, c_a3;
   logic signed [63:0] h_n1, h_n2;
   logic signed [63:0] t_r;
   logic signed [63:0] n1_new;
   logic [CH_W-1:0]    ch_r;
   logic               ch_ok_r;
   logic               clr_pend;
   logic signed [31:0] out_y_r;
   logic [CH_W-1:0]    out_ch_r;

   logic               accept;
   logic               in_ok;
   logic               cfg_ok;
   logic               clr_now;
   logic signed [31:0] mul_a, mul_b;
   logic signed [63:0] prod;
   logic signed [63:0] acc_b1;
   logic signed [31:0] y_nxt;

   assign accept  = bus.in_valid && (state == IDLE);
   assign in_ok   = (CH_W+1)'(bus.in_ch)  < (CH_W+1)'(NCH);
   assign cfg_ok  = (CH_W+1)'(bus.cfg_ch) < (CH_W+1)'(NCH);
   assign clr_now = clr_pend || bus.st_clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = P_B1;
         P_B1:    state_nxt = P_B2;
         P_B2:    state_nxt = P_A2;
         P_A2:    state_nxt = P_B3;
         P_B3:    state_nxt = P_A3;
         P_A3:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state != IDLE);
      bus.out_y     = out_y_r;
      bus.out_ch    = out_ch_r;
   end

   // the single shared multiplier: operand pair chosen by the product step
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state)
         P_B1: begin mul_a = c_b1; mul_b = x_r; end
         P_B2: begin mul_a = c_b2; mul_b = x_r; end
         P_A2: begin mul_a = c_a2; mul_b = y_r; end
         P_B3: begin mul_a = c_b3; mul_b = x_r; end
         P_A3: begin mul_a = c_a3; mul_b = y_r; end
         default: begin mul_a = '0; mul_b = '0; end
      endcase
   end

   assign prod   = 64'(mul_a) * 64'(mul_b);
   assign acc_b1 = h_n1 + prod;
   assign y_nxt  = ch_ok_r ? 32'(acc_b1 >>> QBITS) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            b1_bank[i] <= '0;
            b2_bank[i] <= '0;
            b3_bank[i] <= '0;
            a2_bank[i] <= '0;
            a3_bank[i] <= '0;
         end
      end else if (bus.cfg_we && cfg_ok) begin
         case (bus.cfg_sel)
            3'd0:    b1_bank[bus.cfg_ch] <= bus.cfg_data;
            3'd1:    b2_bank[bus.cfg_ch] <= bus.cfg_data;
            3'd2:    b3_bank[bus.cfg_ch] <= bus.cfg_data;
            3'd3:    a2_bank[bus.cfg_ch] <= bus.cfg_data;
            3'd4:    a3_bank[bus.cfg_ch] <= bus.cfg_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            n1_bank[i] <= '0;
            n2_bank[i] <= '0;
         end
         x_r      <= '0;
         y_r      <= '0;
         c_b1     <= '0;
         c_b2     <= '0;
         c_b3     <= '0;
         c_a2     <= '0;
         c_a3     <= '0;
         h_n1     <= '0;
         h_n2     <= '0;
         t_r      <= '0;
         n1_new   <= '0;
         ch_r     <= '0;
         ch_ok_r  <= 1'b0;
         clr_pend <= 1'b0;
         out_y_r  <= '0;
         out_ch_r <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  // snapshot: a same-edge coefficient write is not seen here
                  x_r     <= bus.in_x;
                  ch_r    <= bus.in_ch;
                  ch_ok_r <= in_ok;
                  c_b1    <= in_ok ? b1_bank[bus.in_ch] : '0;
                  c_b2    <= in_ok ? b2_bank[bus.in_ch] : '0;
                  c_b3    <= in_ok ? b3_bank[bus.in_ch] : '0;
                  c_a2    <= in_ok ? a2_bank[bus.in_ch] : '0;
                  c_a3    <= in_ok ? a3_bank[bus.in_ch] : '0;
                  h_n1    <= in_ok ? n1_bank[bus.in_ch] : '0;
                  h_n2    <= in_ok ? n2_bank[bus.in_ch] : '0;
                  if (bus.st_clr) clr_pend <= 1'b1;
               end else if (bus.st_clr) begin
                  for (int i = 0; i < NCH; i++) begin
                     n1_bank[i] <= '0;
                     n2_bank[i] <= '0;
                  end
               end
            end
            P_B1: y_r    <= y_nxt;
            P_B2: t_r    <= h_n2 + prod;
            P_A2: n1_new <= t_r - prod;
            P_B3: t_r    <= prod;
            P_A3: begin
               t_r      <= t_r - prod;
               out_y_r  <= y_r;
               out_ch_r <= ch_r;
            end
            DONE: begin
               // a pending clear wins over the write-back of this sample
               if (clr_now) begin
                  for (int i = 0; i < NCH; i++) begin
                     n1_bank[i] <= '0;
                     n2_bank[i] <= '0;
                  end
               end else if (ch_ok_r) begin
                  n1_bank[ch_r] <= n1_new;
                  n2_bank[ch_r] <= t_r;
               end
               clr_pend <= 1'b0;
            end
            default: ;
         endcase
         if (bus.st_clr && (state != IDLE) && (state != DONE)) begin
            clr_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iir_chan_sched.sv
// Bench for iir_chan_sched: directed vector table, hand-built corner sequences and a
// randomized run scored against a per-sample arithmetic model of the biquad equations.
module tb_iir_chan_sched;

   logic clk = 1'b0;
   logic reset = 1'b0;

   iir_chan_sched_if #(.CH_W(2)) bus ();

   iir_chan_sched #(.NCH(4), .CH_W(2), .QBITS(27)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state: coefficient index 0=b1 1=b2 2=b3 3=a2 4=a3
   int     m_coef [4][5];
   longint m_n1 [4];
   longint m_n2 [4];

   typedef struct {
      int ch;
      int x;
      int y;
   } vec_t;

   vec_t tab [13];

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         for (int s = 0; s < 5; s++) m_coef[c][s] = 0;
         m_n1[c] = 0;
         m_n2[c] = 0;
      end
   endfunction

   function automatic void model_clear_hist();
      for (int c = 0; c < 4; c++) begin
         m_n1[c] = 0;
         m_n2[c] = 0;
      end
   endfunction

   function automatic void model_cfg(input int ch, input int sel, input int data);
      if (sel < 5) m_coef[ch][sel] = data;
   endfunction

   function automatic int model_step(input int ch, input int x);
      longint acc;
      int     y;
      acc = m_n1[ch] + longint'(m_coef[ch][0]) * longint'(x);
      y = int'(acc >>> 27);
      m_n1[ch] = longint'(m_coef[ch][1]) * longint'(x) + m_n2[ch] - longint'(m_coef[ch][3]) * longint'(y);
      m_n2[ch] = longint'(m_coef[ch][2]) * longint'(x) - longint'(m_coef[ch][4]) * longint'(y);
      return y;
   endfunction

   task automatic cfg_write(input int ch, input int sel, input int data);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = 2'(ch);
      bus.cfg_sel  = 3'(sel);
      bus.cfg_data = data;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      model_cfg(ch, sel, data);
   endtask

   task automatic idle_clear();
      @(negedge clk);
      bus.st_clr = 1'b1;
      @(negedge clk);
      bus.st_clr = 1'b0;
      model_clear_hist();
   endtask

   // side actions (st_clr / cfg write) fire in cycle clr_at / cfg_at counted from the accept cycle
   task automatic run_sample(input int ch, input int x, input int clr_at, input int cfg_at,
                             input int cch, input int csel, input int cdata,
                             output int y, output int och, output int lat,
                             output int rdy_low, output int rdy_after, output int vld_after);
      int guard;
      y = 0; och = -1; lat = -1; rdy_low = 0; rdy_after = -1; vld_after = -1;
      @(negedge clk);
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b1;
      bus.in_ch    = 2'(ch);
      bus.in_x     = x;
      bus.st_clr   = (clr_at == 0);
      bus.cfg_we   = (cfg_at == 0);
      bus.cfg_ch   = 2'(cch);
      bus.cfg_sel  = 3'(csel);
      bus.cfg_data = cdata;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.st_clr = (k == clr_at);
         bus.cfg_we = (k == cfg_at);
         if (bus.in_ready !== 1'b1) rdy_low++;
         if (bus.out_valid === 1'b1) begin
            y   = bus.out_y;
            och = int'(bus.out_ch);
            lat = k;
            break;
         end
      end
      @(negedge clk);
      bus.st_clr = 1'b0;
      bus.cfg_we = 1'b0;
      rdy_after  = int'(bus.in_ready);
      vld_after  = int'(bus.out_valid);
   endtask

   task automatic sample_chk(input string name, input int ch, input int x,
                             input bit use_tab, input int tab_y,
                             input int clr_at, input int cfg_at,
                             input int cch, input int csel, input int cdata);
      int y, och, lat, rl, ra, va, exp_y;
      exp_y = model_step(ch, x);
      if (use_tab) exp_y = tab_y;
      run_sample(ch, x, clr_at, cfg_at, cch, csel, cdata, y, och, lat, rl, ra, va);
      if (cfg_at >= 0) model_cfg(cch, csel, cdata);
      if (clr_at >= 0) model_clear_hist();
      chk({name, ".y"}, y, exp_y);
      chk({name, ".ch"}, och, ch);
      chk({name, ".latency"}, lat, 6);
      chk({name, ".ready_low_cycles"}, rl, 6);
      chk({name, ".ready_after"}, ra, 1);
      chk({name, ".valid_after"}, va, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int vcount;
      int r, ch, x, clr_at, cfg_at, cch, csel, cdata;

      bus.in_valid = 1'b0;
      bus.in_ch    = '0;
      bus.in_x     = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_sel  = '0;
      bus.cfg_data = '0;
      bus.st_clr   = 1'b0;
      model_reset();

      tab[0]  = '{0, 7, 0};
      tab[1]  = '{1, -7, -4};
      tab[2]  = '{0, 7, 0};
      tab[3]  = '{1, -7, -4};
      tab[4]  = '{0, 1000, 1000};
      tab[5]  = '{0, -5, -5};
      tab[6]  = '{2, 1024, 1024};
      tab[7]  = '{3, 50, 0};
      tab[8]  = '{2, 0, 512};
      tab[9]  = '{3, 0, 0};
      tab[10] = '{2, 0, 256};
      tab[11] = '{3, 0, 50};
      tab[12] = '{2, 0, 128};

      repeat (3) @(negedge clk);
      chk("reset.in_ready", bus.in_ready, 1);
      chk("reset.out_valid", bus.out_valid, 0);
      chk("reset.out_y", bus.out_y, 0);
      chk("reset.out_ch", bus.out_ch, 0);
      chk("reset.busy", bus.busy, 0);
      @(negedge clk);
      reset = 1'b1;

      // channel isolation: only ch1 has a coefficient
      cfg_write(1, 0, 67108864);
      for (int i = 0; i < 4; i++)
         sample_chk($sformatf("iso%0d", i), tab[i].ch, tab[i].x, 1'b1, tab[i].y, -1, -1, 0, 0, 0);

      // passthrough, feedback and two-sample delay channels, interleaved
      cfg_write(0, 0, 134217728);
      cfg_write(2, 0, 134217728);
      cfg_write(2, 3, -67108864);
      cfg_write(3, 2, 134217728);
      for (int i = 4; i < 13; i++)
         sample_chk($sformatf("vec%0d", i), tab[i].ch, tab[i].x, 1'b1, tab[i].y, -1, -1, 0, 0, 0);

      // idle clear wipes ch2 history (would otherwise give 64)
      idle_clear();
      sample_chk("idleclr", 2, 0, 1'b1, 0, -1, -1, 0, 0, 0);
      // clear requested mid-sample: that sample still completes, history is gone afterwards
      sample_chk("busyclr.a", 2, 1024, 1'b1, 1024, -1, -1, 0, 0, 0);
      sample_chk("busyclr.b", 2, 0, 1'b1, 512, 2, -1, 0, 0, 0);
      sample_chk("busyclr.c", 2, 0, 1'b1, 0, -1, -1, 0, 0, 0);
      // coefficient write on the acceptance edge: snapshot keeps the old value
      sample_chk("cfgacc.a", 1, -7, 1'b1, -4, -1, 0, 1, 0, 134217728);
      sample_chk("cfgacc.b", 1, -7, 1'b1, -7, -1, -1, 0, 0, 0);
      // coefficient write during P_A2 affects only the next sample
      sample_chk("cfgmid.a", 0, 300, 1'b1, 300, -1, 3, 0, 0, 0);
      sample_chk("cfgmid.b", 0, 300, 1'b1, 0, -1, -1, 0, 0, 0);
      sample_chk("preload", 2, 1024, 1'b1, 1024, -1, -1, 0, 0, 0);

      // reset dropped during P_B3
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_ch    = 2'd0;
      bus.in_x     = 77;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst.busy_before", bus.busy, 1);
      reset = 1'b0;
      #1;
      chk("rst.out_valid", bus.out_valid, 0);
      chk("rst.in_ready", bus.in_ready, 1);
      chk("rst.busy", bus.busy, 0);
      @(negedge clk);
      reset = 1'b1;
      vcount = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) vcount++;
      end
      chk("rst.no_pulse", vcount, 0);
      chk("rst.in_ready_after", bus.in_ready, 1);
      chk("rst.out_y_after", bus.out_y, 0);
      chk("rst.out_ch_after", bus.out_ch, 0);
      model_reset();
      sample_chk("rst.coef_cleared", 2, 1024, 1'b1, 0, -1, -1, 0, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            cch   = $urandom_range(0, 3);
            csel  = $urandom_range(0, 7);
            cdata = int'($urandom_range(0, 268435456)) - 134217728;
            cfg_write(cch, csel, cdata);
         end else if (r == 2) begin
            idle_clear();
         end else begin
            ch     = $urandom_range(0, 3);
            x      = int'($urandom_range(0, 2000000)) - 1000000;
            clr_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
            cfg_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            cch    = $urandom_range(0, 3);
            csel   = $urandom_range(0, 7);
            cdata  = int'($urandom_range(0, 268435456)) - 134217728;
            sample_chk($sformatf("rnd%0d", i), ch, x, 1'b0, 0, clr_at, cfg_at, cch, csel, cdata);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iir_chan_sched.md
Name: iir_chan_sched

Overview:
- Time-multiplexed scheduler and datapath for the team's Q27 biquad section.
- Shares one 32x32 signed multiplier across NCH independent audio channels.
- Holds per-channel coefficients and per-channel history state (n1, n2).
- Sequences the five biquad products for one sample at a time and returns each filtered sample with its channel tag.

Parameters:
- NCH, 4, number of channels (>=2).
- CH_W, 2, channel index width, = clog2(NCH).
- QBITS, 27, coefficient fraction bits; output is the accumulator shifted right arithmetically by QBITS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  sample request.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CH_W  channel of the input sample.
- in_x  in  32  signed input sample.
- out_valid  out  1  one-cycle pulse; the output sample is valid.
- out_ch  out  CH_W  channel of out_y.
- out_y  out  32  signed filtered sample.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_sel  in  3  target coefficient: 0=b1, 1=b2, 2=b3, 3=a2, 4=a3; 5-7 ignored.
- cfg_data  in  32  signed Q27 coefficient value.
- st_clr  in  1  request to clear the history of all channels.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, while reset=0):
  - All coefficients, n1 and n2 of every channel, and all working registers go to 0.
  - FSM goes to IDLE; in_ready=1, out_valid=0, out_y=0, out_ch=0, busy=0, clr_pend=0.
- Filter equations (transposed DF2, a1 implicit 1.0):
  - acc = n1 + b1*x; y = acc >>> QBITS, truncated to 32 bits (bits [QBITS+31:QBITS]).
  - n1' = b2*x + n2 - a2*y.
  - n2' = b3*x - a3*y.
- Width and arithmetic rules: products are 64-bit signed; all sums are 64-bit two's-complement and wrap with no saturation.
- FSM states: IDLE -> P_B1 -> P_B2 -> P_A2 -> P_B3 -> P_A3 -> DONE -> IDLE. One multiply per state.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch x, the channel, that channel's 5 coefficients (snapshot) and its n1/n2, then go to P_B1.
- P_B1: compute y and register it.
- P_B2: t = n2 + b2*x.
- P_A2: n1' = t - a2*y.
- P_B3: t = b3*x.
- P_A3: n2' = t - a3*y.
- DONE:
  - Write n1'/n2' to the channel's history; out_valid=1, out_y=y, out_ch=channel; return to IDLE.
- Latency and throughput:
  - Acceptance edge = cycle 0; out_valid is high in cycle 6.
  - in_ready is low in cycles 1-6 and high again in cycle 7.
  - Throughput is one sample per 7 cycles.
- out_y and out_ch hold their value until the next DONE. out_valid is high only in DONE.
- in_valid while in_ready=0 is ignored. The requester must hold in_valid, in_ch and in_x until accepted.
- Coefficient writes:
  - Accepted on any cycle and land in the bank on the next edge.
  - The in-flight sample uses its snapshot, so a write to the active channel affects only that channel's next sample.
  - cfg_sel 5-7: no effect.
- cfg_we in the same cycle as acceptance on the same channel/coefficient: the snapshot takes the OLD value.
- st_clr:
  - In IDLE with no accept in the same cycle: all n1/n2 are cleared on the next edge.
  - When busy, or accepting in the same cycle: set clr_pend. At DONE, clear all histories instead of writing back. out_y of that sample is still delivered. clr_pend is then cleared.
- in_ch >= NCH (NCH not a power of 2): the sample is accepted, out_valid still pulses with out_y=0, and no history is written.
- Reset mid-operation: the in-flight sample is discarded with no out_valid pulse; all state returns to reset values.

Test Plan:
- Passthrough: ch0 b1=134217728, others 0; x=1000 then x=-5 -> out_y=1000 then -5, out_ch=0. out_valid exactly 6 cycles after each accept; in_ready low for 6 cycles.
- Channel isolation: ch1 b1=67108864; interleave ch0 x=7 and ch1 x=-7 -> ch0 y=0 (coefficients still reset), ch1 y=-4 (arithmetic floor). Neither channel's history affects the other.
- Feedback: ch2 b1=134217728, a2=-67108864; x=1024,0,0,0 -> y=1024,512,256,128.
- Two-sample delay: ch3 b3=134217728, others 0; x=50,0,0 -> y=0,0,50.
- st_clr while busy: feedback setup on ch2; after y=1024, assert st_clr during the x=0 computation -> that sample still gives y=512; the next x=0 gives y=0.
- Coefficient write mid-sample plus reset: write ch0 b1=0 in P_A2 -> the current y uses the old b1 and the next sample y=0. Drop reset in P_B3 -> no out_valid; in_ready=1 and out_y=0 after release.
